// File: rtl/wb_trace_streamer_pkg.sv
// Shared types and constants for the writeback trace streamer.
package trace_pkg;

  // One captured register write, in FIFO storage order.
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
  } trace_entry_t;

  localparam logic [7:0] HDR_OK      = 8'hA5;
  localparam logic [7:0] HDR_LOSS    = 8'hA6;
  localparam int         FRAME_BYTES = 10;
  localparam int         FRAME_W     = 8 * FRAME_BYTES;
  localparam int         ENTRY_W     = $bits(trace_entry_t);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } trace_state_e;

  // Lays out a frame with byte0 in the low byte: header, rd, pc (LE), data (LE).
  function automatic logic [FRAME_W-1:0] build_frame(input trace_entry_t e, input logic loss);
    logic [7:0] hdr;
    hdr = loss ? HDR_LOSS : HDR_OK;
    build_frame = {e.data, e.pc, 3'b000, e.rd, hdr};
  endfunction

endpackage

// File: rtl/wb_trace_streamer_if.sv
// Bus bundles for the trace streamer: writeback tap in, byte stream out.

// Writeback tap; the core side drives it, the streamer observes it.
interface wb_trace_wb_if;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] wb_pc;

  modport master (output wb_we, wb_rd, wb_data, wb_pc);
  modport slave  (input  wb_we, wb_rd, wb_data, wb_pc);
endinterface

// Byte-wide valid/ready stream; the streamer is the master.
interface wb_trace_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, tx_valid, input  tx_ready);
  modport slave  (input  tx_data, tx_valid, output tx_ready);
endinterface

// File: rtl/wb_trace_streamer_sync_fifo.sv
// Single-clock FIFO with registered full/empty flags. A push into a full
// FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1'b1);
  localparam logic [AW:0]   CNT_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             full_r;
  logic             empty_r;
  logic             do_push_s;
  logic             do_pop_s;
  logic [AW:0]      count_next_s;

  // Qualify requests against the flags and work out the next occupancy.
  always_comb begin
    do_pop_s  = pop && !empty_r;
    do_push_s = push && (!full_r || do_pop_s);
    if (do_push_s && !do_pop_s) begin
      count_next_s = count_r + CNT_ONE;
    end else if (do_pop_s && !do_push_s) begin
      count_next_s = count_r - CNT_ONE;
    end else begin
      count_next_s = count_r;
    end
  end

  // Pointers, occupancy and the registered flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= CNT_ZERO;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_next_s;
      full_r  <= (count_next_s == CNT_FULL);
      empty_r <= (count_next_s == CNT_ZERO);
    end
  end

  // Storage array; contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_ptr_r];
  assign full    = full_r;
  assign empty   = empty_r;
  assign count   = count_r;

endmodule

// File: rtl/wb_trace_streamer.sv
// Writeback trace streamer: captures retiring register writes into a FIFO and
// serialises each one as a 10-byte frame on a byte-wide valid/ready port.
module wb_trace_streamer
  import trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             trace_en,
  wb_trace_wb_if.slave     wb,
  wb_trace_tx_if.master    tx,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             busy
);
  localparam int            CW        = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] ONE_ENTRY = CW'(1'b1);
  localparam logic [3:0]    LAST_IDX  = 4'(FRAME_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_INC = CNT_W'(1'b1);

  trace_state_e       state_r, state_next_s;
  logic [FRAME_W-1:0] frame_r, frame_next_s;
  logic [3:0]         byte_idx_r, idx_next_s, idx_inc_s;
  logic [7:0]         tx_data_r, tx_data_next_s;
  logic               tx_valid_r, tx_valid_next_s;
  logic               loss_r, loss_next_s;
  logic [CNT_W-1:0]   drop_cnt_r, drop_cnt_next_s;
  logic               busy_r, busy_next_s;

  logic               event_s;
  logic               drop_s;
  logic               fifo_push_s;
  logic               fifo_pop_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic [CW-1:0]      fifo_count_s;
  trace_entry_t       entry_in_s;
  trace_entry_t       fifo_head_s;
  logic [ENTRY_W-1:0] fifo_rd_data_s;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (fifo_push_s),
    .pop     (fifo_pop_s),
    .wr_data (entry_in_s),
    .rd_data (fifo_rd_data_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .count   (fifo_count_s)
  );

  assign fifo_head_s = trace_entry_t'(fifo_rd_data_s);

  // Capture qualification; a full FIFO only loses the event if nothing pops this cycle.
  always_comb begin
    event_s          = trace_en && wb.wb_we && (wb.wb_rd != 5'd0);
    drop_s           = event_s && fifo_full_s && !fifo_pop_s;
    fifo_push_s      = event_s && !drop_s;
    entry_in_s.pc    = wb.wb_pc;
    entry_in_s.rd    = wb.wb_rd;
    entry_in_s.data  = wb.wb_data;
  end

  // Serialiser next-state: pops frames and advances the registered output byte.
  always_comb begin
    state_next_s    = state_r;
    frame_next_s    = frame_r;
    idx_next_s      = byte_idx_r;
    tx_valid_next_s = tx_valid_r;
    tx_data_next_s  = tx_data_r;
    fifo_pop_s      = 1'b0;
    idx_inc_s       = byte_idx_r + 4'd1;
    case (state_r)
      IDLE: begin
        tx_valid_next_s = 1'b0;
        if (!fifo_empty_s) begin
          fifo_pop_s   = 1'b1;
          frame_next_s = build_frame(fifo_head_s, loss_r);
          idx_next_s   = 4'd0;
          state_next_s = SEND;
        end else begin
          state_next_s = IDLE;
        end
      end
      SEND: begin
        if (!tx_valid_r) begin
          // Frame was just loaded from IDLE; present its header.
          tx_valid_next_s = 1'b1;
          tx_data_next_s  = frame_r[7:0];
        end else if (tx.tx_ready) begin
          if (byte_idx_r == LAST_IDX) begin
            if (!fifo_empty_s) begin
              // Chain straight into the next frame with no idle beat.
              fifo_pop_s     = 1'b1;
              frame_next_s   = build_frame(fifo_head_s, loss_r);
              idx_next_s     = 4'd0;
              tx_data_next_s = frame_next_s[7:0];
            end else begin
              state_next_s    = IDLE;
              tx_valid_next_s = 1'b0;
            end
          end else begin
            idx_next_s     = idx_inc_s;
            tx_data_next_s = 8'(frame_r >> {idx_inc_s, 3'b000});
          end
        end else begin
          // Stalled: hold the current byte.
          tx_data_next_s = tx_data_r;
        end
      end
      default: begin
        state_next_s    = IDLE;
        tx_valid_next_s = 1'b0;
      end
    endcase
  end

  // Loss flag, saturating drop counter and busy indication for the next cycle.
  always_comb begin
    if (drop_s) begin
      loss_next_s = 1'b1;
    end else if (fifo_pop_s) begin
      loss_next_s = 1'b0;
    end else begin
      loss_next_s = loss_r;
    end
    if (drop_s && (drop_cnt_r != {CNT_W{1'b1}})) begin
      drop_cnt_next_s = drop_cnt_r + CNT_INC;
    end else begin
      drop_cnt_next_s = drop_cnt_r;
    end
    busy_next_s = (state_next_s == SEND) || fifo_push_s ||
                  (fifo_pop_s ? (fifo_count_s > ONE_ENTRY) : !fifo_empty_s);
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      frame_r    <= {FRAME_W{1'b0}};
      byte_idx_r <= 4'd0;
      tx_valid_r <= 1'b0;
      tx_data_r  <= 8'h00;
      loss_r     <= 1'b0;
      drop_cnt_r <= {CNT_W{1'b0}};
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      frame_r    <= frame_next_s;
      byte_idx_r <= idx_next_s;
      tx_valid_r <= tx_valid_next_s;
      tx_data_r  <= tx_data_next_s;
      loss_r     <= loss_next_s;
      drop_cnt_r <= drop_cnt_next_s;
      busy_r     <= busy_next_s;
    end
  end

  assign tx.tx_data  = tx_data_r;
  assign tx.tx_valid = tx_valid_r;
  assign drop_cnt    = drop_cnt_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_wb_trace_streamer.sv
// Self-checking bench for wb_trace_streamer: directed scenarios plus a
// randomized phase, all compared against a transaction-level model of the
// event queue and the expected byte stream.
module tb_wb_trace_streamer;
  import trace_pkg::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             trace_en;
  logic [CNT_W-1:0] drop_cnt;
  logic             busy;

  wb_trace_wb_if wbb ();
  wb_trace_tx_if txb ();

  wb_trace_streamer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .trace_en (trace_en),
    .wb       (wbb),
    .tx       (txb),
    .drop_cnt (drop_cnt),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int checks;
  int failures;

  // Reference model: pending events, bytes still owed for the current frame.
  trace_entry_t mq[$];
  logic [7:0]   exp_q[$];
  int           m_stage;   // 0 nothing in flight, 1 frame loaded but not shown, 2 showing bytes
  logic         m_valid;
  logic         m_loss;
  logic [15:0]  m_drops;
  logic         m_busy;

  // Observation helpers for directed scenarios.
  logic [7:0] cap_q[$];
  int         beats;
  int         run_len;
  int         max_run;

  logic [7:0] single_exp [10] = '{8'hA5, 8'h05, 8'h10, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
  logic [7:0] bp_exp     [10] = '{8'hA5, 8'h09, 8'h04, 8'h01, 8'h00, 8'h80, 8'hEF, 8'hBE, 8'hAD, 8'hDE};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    exp_q.delete();
    m_stage = 0;
    m_valid = 1'b0;
    m_loss  = 1'b0;
    m_drops = 16'd0;
    m_busy  = 1'b0;
  endfunction

  function automatic void push_frame(input trace_entry_t e, input logic loss);
    exp_q.push_back(loss ? 8'hA6 : 8'hA5);
    exp_q.push_back({3'b000, e.rd});
    for (int b = 0; b < 4; b++) exp_q.push_back(8'(e.pc >> (8 * b)));
    for (int b = 0; b < 4; b++) exp_q.push_back(8'(e.data >> (8 * b)));
  endfunction

  // Advance the model across one clock edge with the inputs presented before it.
  function automatic void model_step(input logic te, input logic we, input logic [4:0] rd,
                                     input logic [31:0] data, input logic [31:0] pc, input logic rdy);
    logic accept, ev, pop, drop, full;
    int old_stage;
    trace_entry_t e;
    old_stage = m_stage;
    accept = m_valid && rdy;
    ev     = te && we && (rd != 5'd0);
    pop    = 1'b0;
    if (old_stage == 0) pop = (mq.size() > 0);
    else if (old_stage == 2 && accept && exp_q.size() == 1) pop = (mq.size() > 0);
    full = (mq.size() == DEPTH);
    drop = ev && full && !pop;
    if (accept) void'(exp_q.pop_front());
    if (old_stage == 1) begin
      m_stage = 2;
      m_valid = 1'b1;
    end else if (old_stage == 2 && accept && exp_q.size() == 0 && !pop) begin
      m_stage = 0;
      m_valid = 1'b0;
    end
    if (pop) begin
      e = mq.pop_front();
      push_frame(e, m_loss);
      if (old_stage == 0) m_stage = 1;
    end
    if (ev && !drop) begin
      e.pc = pc; e.rd = rd; e.data = data;
      mq.push_back(e);
    end
    if (drop) begin
      m_loss = 1'b1;
      if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
    end else if (pop) begin
      m_loss = 1'b0;
    end
    m_busy = (mq.size() > 0) || (m_stage != 0);
  endfunction

  // One clock: check outputs against the model, drive inputs, step model, advance.
  task automatic cycle(input logic te, input logic we, input logic [4:0] rd,
                       input logic [31:0] data, input logic [31:0] pc, input logic rdy);
    chk("tx_valid", 32'(txb.tx_valid), 32'(m_valid));
    if (m_valid) chk("tx_data", 32'(txb.tx_data), 32'(exp_q[0]));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drops));
    if (txb.tx_valid) run_len++; else run_len = 0;
    if (run_len > max_run) max_run = run_len;
    trace_en      = te;
    wbb.wb_we     = we;
    wbb.wb_rd     = rd;
    wbb.wb_data   = data;
    wbb.wb_pc     = pc;
    txb.tx_ready  = rdy;
    if (txb.tx_valid && rdy) begin
      cap_q.push_back(txb.tx_data);
      beats++;
    end
    model_step(te, we, rd, data, pc, rdy);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 5'd0, 32'd0, 32'd0, rdy);
  endtask

  task automatic clear_obs();
    cap_q.delete();
    beats   = 0;
    run_len = 0;
    max_run = 0;
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst_n        = 1'b0;
    trace_en     = 1'b0;
    wbb.wb_we    = 1'b0;
    wbb.wb_rd    = 5'd0;
    wbb.wb_data  = 32'd0;
    wbb.wb_pc    = 32'd0;
    txb.tx_ready = 1'b0;
    model_reset();
    clear_obs();
    repeat (3) @(negedge clk);
    chk("rst_tx_valid", 32'(txb.tx_valid), 32'd0);
    chk("rst_tx_data",  32'(txb.tx_data),  32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt),     32'd0);
    chk("rst_busy",     32'(busy),         32'd0);
    rst_n = 1'b1;

    // Single event with exact latency and byte content.
    clear_obs();
    cycle(1'b1, 1'b1, 5'd5, 32'h1234_5678, 32'h0000_0010, 1'b1);
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
    chk("lat_e1_valid", 32'(txb.tx_valid), 32'd0);
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
    chk("lat_e2_valid", 32'(txb.tx_valid), 32'd1);
    chk("lat_e2_hdr",   32'(txb.tx_data),  32'hA5);
    idle(15, 1'b1);
    chk("single_beats", 32'(cap_q.size()), 32'd10);
    if (cap_q.size() == 10)
      for (int i = 0; i < 10; i++) chk("single_byte", 32'(cap_q[i]), 32'(single_exp[i]));
    chk("single_end_valid", 32'(txb.tx_valid), 32'd0);
    chk("single_end_busy",  32'(busy),         32'd0);

    // x0 writes and gated events are neither captured nor dropped.
    clear_obs();
    cycle(1'b1, 1'b1, 5'd0, 32'hAAAA_0000, 32'h100, 1'b1);
    cycle(1'b0, 1'b1, 5'd3, 32'hBBBB_0000, 32'h104, 1'b1);
    idle(10, 1'b1);
    chk("filter_beats", 32'(beats),    32'd0);
    chk("filter_drops", 32'(drop_cnt), 32'd0);

    // Backpressure: ready 1,0,0 repeating across one frame.
    clear_obs();
    cycle(1'b1, 1'b1, 5'd9, 32'hDEAD_BEEF, 32'h8000_0104, 1'b1);
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, 5'd0, 32'd0, 32'd0, (i % 3) == 0);
    chk("bp_beats", 32'(beats), 32'd10);
    if (cap_q.size() == 10)
      for (int i = 0; i < 10; i++) chk("bp_byte", 32'(cap_q[i]), 32'(bp_exp[i]));

    // Overflow: 12 events against a stalled consumer.
    clear_obs();
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, 5'(i + 1), $urandom, $urandom, 1'b0);
    chk("ovf_drops", 32'(drop_cnt), 32'd3);
    idle(120, 1'b1);
    chk("ovf_beats", 32'(cap_q.size()), 32'd90);
    if (cap_q.size() == 90)
      for (int k = 0; k < 9; k++) begin
        chk("ovf_hdr", 32'(cap_q[10 * k]), (k == 1) ? 32'hA6 : 32'hA5);
        chk("ovf_rd",  32'(cap_q[10 * k + 1]), 32'(k + 1));
      end
    chk("ovf_end_busy", 32'(busy), 32'd0);

    // Back-to-back frames: 30 consecutive valid beats.
    clear_obs();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 5'(i + 20), $urandom, $urandom, 1'b1);
    idle(40, 1'b1);
    chk("b2b_beats",   32'(beats),   32'd30);
    chk("b2b_max_run", 32'(max_run), 32'd30);

    // Reset in the middle of a frame, with drops already counted.
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, 5'(i + 1), $urandom, $urandom, 1'b0);
    idle(4, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(txb.tx_valid), 32'd0);
    chk("mid_rst_busy",  32'(busy),         32'd0);
    chk("mid_rst_drops", 32'(drop_cnt),     32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_obs();
    idle(30, 1'b1);
    chk("post_rst_beats", 32'(beats),    32'd0);
    chk("post_rst_drops", 32'(drop_cnt), 32'd0);

    // Randomized traffic: mostly-ready then mostly-stalled consumer.
    for (int i = 0; i < 600; i++)
      cycle(($urandom % 8) != 0, $urandom_range(0, 1) == 1, 5'($urandom % 32),
            $urandom, $urandom, (i < 300) ? (($urandom % 4) != 0) : (($urandom % 4) == 0));
    idle(200, 1'b1);
    chk("rand_end_busy", 32'(busy), 32'd0);
    chk("rand_drops",    32'(drop_cnt), 32'(m_drops));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
